// File: rtl/buttons_pkg.sv
// Shared constants for the elevator request register.
//   BLK_W      : width of the buttons_blocked mask
//   BLK_IN     : mask bit that blocks cabin presses
//   BLK_UP     : mask bit that blocks hall up-call presses
//   BLK_DOWN   : mask bit that blocks hall down-call presses
package buttons_pkg;

    localparam int unsigned BLK_W    = 5;
    localparam int unsigned BLK_IN   = 0;
    localparam int unsigned BLK_UP   = 1;
    localparam int unsigned BLK_DOWN = 2;

endpackage : buttons_pkg

// File: rtl/buttons_request_latch.sv
// One vector of pending requests: rising-edge press detection, block gate,
// level-sensitive clear (clear beats press) and a static mask of levels on
// which a request can never exist.
//   clk     : system clock
//   reset   : synchronous active-low reset
//   blocked : when high, presses are discarded (clears still act)
//   btn     : raw buttons, high while pressed
//   clr     : per-level clear, level-sensitive
//   active  : pending requests (registered)
module buttons_request_latch #(
    parameter int unsigned          WIDTH      = 8,
    parameter logic [WIDTH-1:0]     VALID_MASK = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             blocked,
    input  logic [WIDTH-1:0] btn,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] active
);

    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] press_c;
    logic [WIDTH-1:0] active_next;

    // Press = rising edge; an edge seen while blocked is simply lost.
    always_comb begin
        press_c     = '0;
        active_next = active;
        if (!blocked) begin
            press_c = btn & ~prev;
        end
        active_next = (active | press_c) & ~clr & VALID_MASK;
    end

    // prev also loads during reset so a button held through reset is not
    // seen as a fresh press afterwards.
    always_ff @(posedge clk) begin
        prev <= btn;
        if (!reset) begin
            active <= '0;
        end else begin
            active <= active_next;
        end
    end

endmodule : buttons_request_latch

// File: rtl/buttons.sv
// Elevator request register: latches cabin, hall-up and hall-down presses
// until the scheduler clears them, and reports a per-level summary.
//   clk                        : system clock
//   reset                      : synchronous active-low reset
//   buttons_blocked            : [0] cabin, [1] up, [2] down block; [4:3] unused
//   btn_in / btn_up_out / btn_down_out           : raw buttons
//   inactivate_in/out_up/out_down_levels         : per-level clears
//   active_in/out_up/out_down_levels             : pending requests (registered)
//   enable                     : per-level OR of the pending vectors
module buttons
    import buttons_pkg::*;
#(
    parameter int unsigned BUTTONS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BLK_W-1:0]         buttons_blocked,
    input  logic [BUTTONS_WIDTH-1:0] btn_in,
    input  logic [BUTTONS_WIDTH-1:0] btn_up_out,
    input  logic [BUTTONS_WIDTH-1:0] btn_down_out,
    input  logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
    input  logic [BUTTONS_WIDTH-1:0] inactivate_out_up_levels,
    input  logic [BUTTONS_WIDTH-1:0] inactivate_out_down_levels,
    output logic [BUTTONS_WIDTH-1:0] active_in_levels,
    output logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
    output logic [BUTTONS_WIDTH-1:0] active_out_down_levels,
    output logic [BUTTONS_WIDTH-1:0] enable
);

    // No up call from the top level, no down call from the bottom level.
    localparam logic [BUTTONS_WIDTH-1:0] MASK_ALL  = '1;
    localparam logic [BUTTONS_WIDTH-1:0] MASK_UP   = MASK_ALL >> 1;
    localparam logic [BUTTONS_WIDTH-1:0] MASK_DOWN = MASK_ALL << 1;

    // Reserved mask bits carry no function.
    logic unused_blocked;
    assign unused_blocked = ^buttons_blocked[BLK_W-1:BLK_DOWN+1];

    buttons_request_latch #(
        .WIDTH      (BUTTONS_WIDTH),
        .VALID_MASK (MASK_ALL)
    ) u_cabin (
        .clk     (clk),
        .reset   (reset),
        .blocked (buttons_blocked[BLK_IN]),
        .btn     (btn_in),
        .clr     (inactivate_in_levels),
        .active  (active_in_levels)
    );

    buttons_request_latch #(
        .WIDTH      (BUTTONS_WIDTH),
        .VALID_MASK (MASK_UP)
    ) u_hall_up (
        .clk     (clk),
        .reset   (reset),
        .blocked (buttons_blocked[BLK_UP]),
        .btn     (btn_up_out),
        .clr     (inactivate_out_up_levels),
        .active  (active_out_up_levels)
    );

    buttons_request_latch #(
        .WIDTH      (BUTTONS_WIDTH),
        .VALID_MASK (MASK_DOWN)
    ) u_hall_down (
        .clk     (clk),
        .reset   (reset),
        .blocked (buttons_blocked[BLK_DOWN]),
        .btn     (btn_down_out),
        .clr     (inactivate_out_down_levels),
        .active  (active_out_down_levels)
    );

    // Summary is a pure function of the three registered vectors.
    assign enable = active_in_levels | active_out_up_levels | active_out_down_levels;

endmodule : buttons

// File: tb/tb_buttons.sv
module tb_buttons;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   buttons_blocked;
    logic [W-1:0] btn_in, btn_up_out, btn_down_out;
    logic [W-1:0] inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels;
    logic [W-1:0] active_in_levels, active_out_up_levels, active_out_down_levels, enable;

    int compared   = 0;
    int mismatched = 0;

    buttons #(.BUTTONS_WIDTH(W)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .buttons_blocked            (buttons_blocked),
        .btn_in                     (btn_in),
        .btn_up_out                 (btn_up_out),
        .btn_down_out               (btn_down_out),
        .inactivate_in_levels       (inactivate_in_levels),
        .inactivate_out_up_levels   (inactivate_out_up_levels),
        .inactivate_out_down_levels (inactivate_out_down_levels),
        .active_in_levels           (active_in_levels),
        .active_out_up_levels       (active_out_up_levels),
        .active_out_down_levels     (active_out_down_levels),
        .enable                     (enable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [4:0]   blk;
        logic [W-1:0] bi, bu, bd;
        logic [W-1:0] ci, cu, cd;
        logic [W-1:0] e_in, e_up, e_dn, e_en;
    } vec_t;

    vec_t vecs[$];

    // Behavioural reference: per-level request flags and last-seen buttons.
    bit m_in[W], m_up[W], m_dn[W];
    bit p_in[W], p_up[W], p_dn[W];

    task automatic add(input logic rst, input logic [4:0] blk,
                       input logic [W-1:0] bi, input logic [W-1:0] bu, input logic [W-1:0] bd,
                       input logic [W-1:0] ci, input logic [W-1:0] cu, input logic [W-1:0] cd,
                       input logic [W-1:0] e_in, input logic [W-1:0] e_up,
                       input logic [W-1:0] e_dn, input logic [W-1:0] e_en);
        vec_t v;
        v.rst = rst; v.blk = blk; v.bi = bi; v.bu = bu; v.bd = bd;
        v.ci = ci; v.cu = cu; v.cd = cd;
        v.e_in = e_in; v.e_up = e_up; v.e_dn = e_dn; v.e_en = e_en;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the rules level by level from the current inputs.
    task automatic model_step();
        for (int i = 0; i < int'(W); i++) begin
            bit pi, pu, pd;
            pi = btn_in[i]       && !p_in[i] && !buttons_blocked[0];
            pu = btn_up_out[i]   && !p_up[i] && !buttons_blocked[1] && (i != int'(W) - 1);
            pd = btn_down_out[i] && !p_dn[i] && !buttons_blocked[2] && (i != 0);
            if (!reset) begin
                m_in[i] = 0; m_up[i] = 0; m_dn[i] = 0;
            end else begin
                if (inactivate_in_levels[i])            m_in[i] = 0;
                else if (pi)                            m_in[i] = 1;
                if (inactivate_out_up_levels[i])        m_up[i] = 0;
                else if (pu)                            m_up[i] = 1;
                if (inactivate_out_down_levels[i])      m_dn[i] = 0;
                else if (pd)                            m_dn[i] = 1;
            end
            p_in[i] = btn_in[i]; p_up[i] = btn_up_out[i]; p_dn[i] = btn_down_out[i];
        end
    endtask

    task automatic check_model(input string tag);
        logic [W-1:0] ei, eu, ed;
        for (int i = 0; i < int'(W); i++) begin
            ei[i] = m_in[i]; eu[i] = m_up[i]; ed[i] = m_dn[i];
        end
        check({tag, ".in"},   active_in_levels,       ei);
        check({tag, ".up"},   active_out_up_levels,   eu);
        check({tag, ".down"}, active_out_down_levels, ed);
        check({tag, ".en"},   enable,                 ei | eu | ed);
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; buttons_blocked = v.blk;
        btn_in = v.bi; btn_up_out = v.bu; btn_down_out = v.bd;
        inactivate_in_levels = v.ci; inactivate_out_up_levels = v.cu;
        inactivate_out_down_levels = v.cd;
    endtask

    initial begin
        //   rst blk   bi     bu     bd     ci     cu     cd     e_in   e_up   e_dn   e_en
        add(0, 5'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add(1, 5'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add(1, 5'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add(1, 5'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add(1, 5'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add(1, 5'h00, 8'h9F, 8'h17, 8'h63, 8'h00, 8'h00, 8'h00, 8'h9F, 8'h17, 8'h62, 8'hFF);
        add(1, 5'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h9F, 8'h17, 8'h62, 8'hFF);
        add(1, 5'h00, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h11, 8'h20, 8'h93, 8'h06, 8'h42, 8'hD7);
        add(1, 5'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
        add(1, 5'h01, 8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h08);
        add(1, 5'h03, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h08);
        add(1, 5'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h08);
        add(1, 5'h00, 8'h40, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h08);
        add(1, 5'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h08);
        add(1, 5'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h08, 8'h00, 8'h48);
        add(1, 5'h00, 8'h00, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h40, 8'h08, 8'h00, 8'h48);
        add(1, 5'h18, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h08, 8'h00, 8'h48);
        add(0, 5'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        add(1, 5'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        foreach (vecs[k]) begin
            drive(vecs[k]);
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.in", k),   active_in_levels,       vecs[k].e_in);
            check($sformatf("vec%0d.up", k),   active_out_up_levels,   vecs[k].e_up);
            check($sformatf("vec%0d.down", k), active_out_down_levels, vecs[k].e_dn);
            check($sformatf("vec%0d.en", k),   enable,                 vecs[k].e_en);
        end

        // Held clear keeps a bit low across repeated presses.
        for (int c = 0; c < 4; c++) begin
            reset = 1'b1; buttons_blocked = 5'h00;
            btn_in = (c % 2 == 0) ? 8'h04 : 8'h00;
            btn_up_out = 8'h00; btn_down_out = 8'h00;
            inactivate_in_levels = 8'h04;
            inactivate_out_up_levels = 8'h00; inactivate_out_down_levels = 8'h00;
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("heldclr%0d.in", c), active_in_levels, 8'h00);
        end

        // Randomised traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            reset           = ($urandom_range(0, 39) != 0);
            buttons_blocked = 5'($urandom_range(0, 3) == 0 ? $urandom : 0);
            btn_in          = btn_in       ^ W'($urandom & $urandom);
            btn_up_out      = btn_up_out   ^ W'($urandom & $urandom);
            btn_down_out    = btn_down_out ^ W'($urandom & $urandom);
            inactivate_in_levels       = W'($urandom & $urandom & $urandom);
            inactivate_out_up_levels   = W'($urandom & $urandom & $urandom);
            inactivate_out_down_levels = W'($urandom & $urandom & $urandom);
            model_step();
            @(posedge clk);
            #1;
            check_model($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_buttons
